mul_pipe: RTL

Parametrised, fully pipelined radix-4 Booth / carry-save-tree multiplier with a valid/ready handshake on both sides, per-operation signed/unsigned mode, a sideband tag and a pipeline flush. It replaces the fixed 32-bit, free-running two-stage multiplier in the execute stage. The handshake supports back-pressure from write-back, and the flush supports exception/branch cancellation. One product per cycle at full throughput; fixed latency of 2 cycles.

---
 rtl/mul_pipe.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/mul_pipe.sv
// mul_pipe: two-stage pipelined radix-4 Booth multiplier with valid/ready
// handshake on both sides, per-operation signed/unsigned mode, a sideband
// tag that travels with each operation, and a synchronous pipeline flush.
//
// Ports:
//   mul_clk    clock, all state on the rising edge
//   resetn     asynchronous active-low reset
//   flush      synchronous kill of everything in flight (and of this cycle's input)
//   in_valid   operands present            in_ready   block can accept this cycle
//   mul_signed 1 = two's complement, 0 = unsigned
//   x, y       multiplicand, multiplier (WIDTH bits)
//   in_tag     sideband tag carried unchanged with the operation
//   out_valid  result present               out_ready  consumer accepts this cycle
//   result     full 2*WIDTH-bit product      out_tag    tag of the operation on result
//
// Stage 1 registers the Booth rows and their negate carries; stage 2 compresses
// them in a carry-save array and finishes with one carry-propagate add.

module mul_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic                 mul_clk,
    input  logic                 resetn,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 mul_signed,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic [TAG_W-1:0]     out_tag
);

    localparam int PW   = 2 * WIDTH;
    localparam int ROWS = WIDTH / 2 + 1;

    logic            v1;
    logic            v2;
    logic            adv1;
    logic            adv2;
    logic            accept;
    logic [PW-1:0]   xExt;
    logic [WIDTH+2:0] yPad;
    logic [PW-1:0]   ppNext [ROWS];
    logic [ROWS-1:0] negNext;
    logic [PW-1:0]   pp1 [ROWS];
    logic [ROWS-1:0] neg1;
    logic [TAG_W-1:0] tag1;
    logic [PW-1:0]   product;

    // A stage may move forward when it is empty or the stage after it moves.
    // in_ready depends only on pipeline state and out_ready, never on in_valid,
    // so upstream can use it without forming a combinational loop.
    always_comb begin
        adv2     = ~v2 | out_ready;
        adv1     = ~v1 | adv2;
        in_ready = adv1;
        accept   = in_valid & in_ready;
    end

    // Booth recoding. x is widened to the full product width and y is padded
    // with an implicit 0 below bit 0 and two extension bits on top, so the last
    // row sees only extension bits above y's MSB. The mode is folded into the
    // extension here, which is why it does not need to be carried further.
    // A negative row is stored inverted only above its own LSB weight, so the
    // single carry-in at that weight completes the two's-complement negation.
    always_comb begin
        logic [2:0]    trip;
        logic [PW-1:0] mag;
        logic          neg;
        xExt = {{WIDTH{mul_signed & x[WIDTH-1]}}, x};
        yPad = {{2{mul_signed & y[WIDTH-1]}}, y, 1'b0};
        for (int i = 0; i < ROWS; i++) begin
            trip = yPad[2*i+2 -: 3];
            mag  = '0;
            neg  = 1'b0;
            case (trip)
                3'b001, 3'b010: mag = xExt;
                3'b011:         mag = xExt << 1;
                3'b100: begin
                    mag = xExt << 1;
                    neg = 1'b1;
                end
                3'b101, 3'b110: begin
                    mag = xExt;
                    neg = 1'b1;
                end
                default:        mag = '0;
            endcase
            ppNext[i]  = (neg ? ~mag : mag) << (2 * i);
            negNext[i] = neg;
        end
    end

    // Stage 1 register: rows, negate carries and tag load only on an accepted
    // operation so a stalled stage keeps its contents. Flush clears the valid
    // bit and discards whatever is being presented in the same cycle.
    always_ff @(posedge mul_clk or negedge resetn) begin
        if (!resetn) begin
            v1   <= 1'b0;
            neg1 <= '0;
            tag1 <= '0;
            for (int i = 0; i < ROWS; i++) begin
                pp1[i] <= '0;
            end
        end else begin
            if (flush) begin
                v1 <= 1'b0;
            end else if (adv1) begin
                v1 <= in_valid;
            end
            if (accept) begin
                neg1 <= negNext;
                tag1 <= in_tag;
                for (int i = 0; i < ROWS; i++) begin
                    pp1[i] <= ppNext[i];
                end
            end
        end
    end

    // Carry-save compression. The negate carries sit at distinct even bit
    // positions, so together they form one extra addend word. Every further
    // row is folded in with a 3:2 compressor, leaving one sum/carry pair for
    // the final carry-propagate adder.
    always_comb begin
        logic [PW-1:0] negWord;
        logic [PW-1:0] sumV;
        logic [PW-1:0] carryV;
        logic [PW-1:0] tmp;
        negWord = '0;
        for (int i = 0; i < ROWS; i++) begin
            negWord[2*i] = neg1[i];
        end
        sumV   = pp1[0];
        carryV = negWord;
        for (int i = 1; i < ROWS; i++) begin
            tmp    = sumV ^ carryV ^ pp1[i];
            carryV = ((sumV & carryV) | (sumV & pp1[i]) | (carryV & pp1[i])) << 1;
            sumV   = tmp;
        end
        product = sumV + carryV;
    end

    // Stage 2 register drives result and out_tag directly, so the outputs have
    // no combinational path from the inputs.
    always_ff @(posedge mul_clk or negedge resetn) begin
        if (!resetn) begin
            v2      <= 1'b0;
            result  <= '0;
            out_tag <= '0;
        end else begin
            if (flush) begin
                v2 <= 1'b0;
            end else if (adv2) begin
                v2 <= v1;
            end
            if (v1 & adv2) begin
                result  <= product;
                out_tag <= tag1;
            end
        end
    end

    assign out_valid = v2;

endmodule
